// File: rtl/simple_pkg.sv
// Shared constants and types for the simple gate block.
// One result lane carries the AND, OR and NOT outputs of a single bit position.
package simple_pkg;

    localparam int SIMPLE_WIDTH = 1;

    typedef struct packed {
        logic and_b;
        logic or_b;
        logic not_b;
    } result_lane_t;

endpackage

// File: rtl/simple_if.sv
// Operand/result bus of the simple gate block: master drives operands, slave returns results.
// The gate modport is the purely combinational view used by the gate bank.
interface simple_if import simple_pkg::*; #(
    parameter int WIDTH = SIMPLE_WIDTH
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] O1;
    logic [WIDTH-1:0] O2;
    logic [WIDTH-1:0] O3;
    logic             chg;

    modport master (output A, B, input O1, O2, O3, chg);
    modport slave  (input A, B, output O1, O2, O3, chg);
    modport gate   (input A, B, output O1, O2, O3);

endinterface

// File: rtl/simple_gate_bank.sv
// Bitwise AND / OR / NOT of the operands; purely combinational, latency 0, no flow control.
module simple_gate_bank (
    simple_if.gate bus
);

    assign bus.O1 = bus.A & bus.B;
    assign bus.O2 = bus.A | bus.B;
    assign bus.O3 = ~bus.A;

endmodule

// File: rtl/simple.sv
// Gate bank plus optional output register and a registered change pulse.
// Latency 1 (REGISTERED=1) or 0 (REGISTERED=0); one result per cycle, no backpressure.
module simple import simple_pkg::*; #(
    parameter int WIDTH      = SIMPLE_WIDTH,
    parameter int REGISTERED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic             chg
);

    simple_if #(.WIDTH(WIDTH)) gate_bus ();

    result_lane_t [WIDTH-1:0] res_d;
    result_lane_t [WIDTH-1:0] res_q;
    result_lane_t [WIDTH-1:0] res_o;
    logic                     chg_q;
    logic                     primed_q;

    assign gate_bus.A   = A;
    assign gate_bus.B   = B;
    assign gate_bus.chg = chg_q;

    simple_gate_bank u_gates (
        .bus(gate_bus)
    );

    always_comb begin
        res_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res_d[i].and_b = gate_bus.O1[i];
            res_d[i].or_b  = gate_bus.O2[i];
            res_d[i].not_b = gate_bus.O3[i];
        end
    end

    // res_q is also the previous-cycle gate result, so it feeds change detection in both modes;
    // primed_q keeps the first load after reset from being reported as a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q    <= '0;
            chg_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            res_q    <= res_d;
            chg_q    <= primed_q && (res_d != res_q);
            primed_q <= 1'b1;
        end
    end

    assign res_o = (REGISTERED != 0) ? res_q : res_d;

    always_comb begin
        O1 = '0;
        O2 = '0;
        O3 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            O1[i] = res_o[i].and_b;
            O2[i] = res_o[i].or_b;
            O3[i] = res_o[i].not_b;
        end
    end

    assign chg = chg_q;

endmodule

// File: tb/tb_simple.sv
// Directed bench for simple: registered 1-bit, registered 8-bit and combinational 1-bit instances.
module tb_simple;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    simple_if #(.WIDTH(1)) b1 ();
    simple_if #(.WIDTH(8)) b8 ();
    simple_if #(.WIDTH(1)) bc ();

    simple #(.WIDTH(1), .REGISTERED(1)) dut_r1 (
        .clk(clk), .rst_n(rst_n), .A(b1.A), .B(b1.B),
        .O1(b1.O1), .O2(b1.O2), .O3(b1.O3), .chg(b1.chg)
    );

    simple #(.WIDTH(8), .REGISTERED(1)) dut_r8 (
        .clk(clk), .rst_n(rst_n), .A(b8.A), .B(b8.B),
        .O1(b8.O1), .O2(b8.O2), .O3(b8.O3), .chg(b8.chg)
    );

    simple #(.WIDTH(1), .REGISTERED(0)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .A(bc.A), .B(bc.B),
        .O1(bc.O1), .O2(bc.O2), .O3(bc.O3), .chg(bc.chg)
    );

    typedef struct {
        logic       a;
        logic       b;
        logic [2:0] o;   // {O1, O2, O3}
    } vec_t;

    vec_t vecs [4];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] r1_o();
        return {5'b0, b1.O1, b1.O2, b1.O3};
    endfunction

    function automatic logic [7:0] c1_o();
        return {5'b0, bc.O1, bc.O2, bc.O3};
    endfunction

    initial begin
        logic [2:0] prev;

        vecs[0] = '{a: 1'b0, b: 1'b0, o: 3'b001};
        vecs[1] = '{a: 1'b0, b: 1'b1, o: 3'b011};
        vecs[2] = '{a: 1'b1, b: 1'b0, o: 3'b010};
        vecs[3] = '{a: 1'b1, b: 1'b1, o: 3'b110};

        rst_n = 1'b0;
        b1.A = 1'b1; b1.B = 1'b1;
        b8.A = 8'h00; b8.B = 8'h00;
        bc.A = 1'b1; bc.B = 1'b1;

        // Reset held with A = B = 1
        repeat (2) @(negedge clk);
        chk("rst_hold_o",   r1_o(), 8'h00);
        chk("rst_hold_chg", {7'b0, b1.chg}, 8'h00);
        chk("comb_in_rst_o", c1_o(), 8'h06);
        chk("comb_in_rst_chg", {7'b0, bc.chg}, 8'h00);

        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_o",   r1_o(), 8'h06);
        chk("rel_chg", {7'b0, b1.chg}, 8'h00);
        @(negedge clk);
        chk("rel_hold_o",   r1_o(), 8'h06);
        chk("rel_hold_chg", {7'b0, b1.chg}, 8'h00);

        // Truth sweep, 5 cycles per pattern
        prev = 3'b110;
        for (int v = 0; v < 4; v++) begin
            b1.A = vecs[v].a;
            b1.B = vecs[v].b;
            #1;
            chk($sformatf("sweep%0d_latency", v), r1_o(), {5'b0, prev});
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk($sformatf("sweep%0d_c%0d_o", v, k), r1_o(), {5'b0, vecs[v].o});
                chk($sformatf("sweep%0d_c%0d_chg", v, k), {7'b0, b1.chg},
                    (k == 0) ? {7'b0, vecs[v].o != prev} : 8'h00);
            end
            prev = vecs[v].o;
        end

        // Change detect: 00 -> 01
        b1.A = 1'b0; b1.B = 1'b0;
        @(negedge clk);
        chk("cd_00_o", r1_o(), 8'h01);
        b1.A = 1'b0; b1.B = 1'b1;
        @(negedge clk);
        chk("cd_01_o2",  {7'b0, b1.O2}, 8'h01);
        chk("cd_01_chg", {7'b0, b1.chg}, 8'h01);
        @(negedge clk);
        chk("cd_hold1_chg", {7'b0, b1.chg}, 8'h00);
        @(negedge clk);
        chk("cd_hold2_chg", {7'b0, b1.chg}, 8'h00);
        chk("cd_hold2_o",   r1_o(), 8'h03);

        // Reset mid-stream while a change pulse is high
        b1.A = 1'b1; b1.B = 1'b1;
        @(negedge clk);
        chk("mid_pre_o",   r1_o(), 8'h06);
        chk("mid_pre_chg", {7'b0, b1.chg}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_o",   r1_o(), 8'h00);
        chk("mid_async_chg", {7'b0, b1.chg}, 8'h00);
        chk("mid_async_w8_o3", b8.O3, 8'h00);
        b1.A = 1'b1; b1.B = 1'b0;
        @(negedge clk);
        chk("mid_in_rst_o", r1_o(), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_o",   r1_o(), 8'h02);
        chk("mid_rel_chg", {7'b0, b1.chg}, 8'h00);
        @(negedge clk);
        chk("mid_rel_hold_o",   r1_o(), 8'h02);
        chk("mid_rel_hold_chg", {7'b0, b1.chg}, 8'h00);

        // Width 8
        chk("w8_post_rst_o3",  b8.O3, 8'hFF);
        chk("w8_post_rst_chg", {7'b0, b8.chg}, 8'h00);
        b8.A = 8'hF0; b8.B = 8'h3C;
        bc.A = 1'b0;  bc.B = 1'b0;
        #1;
        chk("w8_latency_o1", b8.O1, 8'h00);
        @(negedge clk);
        chk("w8_f0_3c_o1",  b8.O1, 8'h30);
        chk("w8_f0_3c_o2",  b8.O2, 8'hFC);
        chk("w8_f0_3c_o3",  b8.O3, 8'h0F);
        chk("w8_f0_3c_chg", {7'b0, b8.chg}, 8'h01);
        b8.A = 8'hAA; b8.B = 8'h55;
        @(negedge clk);
        chk("w8_aa_55_o1", b8.O1, 8'h00);
        chk("w8_aa_55_o2", b8.O2, 8'hFF);
        chk("w8_aa_55_o3", b8.O3, 8'h55);

        // Combinational mode: result without a clock edge, chg one edge later
        chk("comb_settled_o",   c1_o(), 8'h01);
        chk("comb_settled_chg", {7'b0, bc.chg}, 8'h00);
        #2;
        bc.A = 1'b1; bc.B = 1'b0;
        #1;
        chk("comb_same_cycle_o",   c1_o(), 8'h02);
        chk("comb_same_cycle_chg", {7'b0, bc.chg}, 8'h00);
        @(negedge clk);
        chk("comb_pulse_chg", {7'b0, bc.chg}, 8'h01);
        @(negedge clk);
        chk("comb_hold_chg", {7'b0, bc.chg}, 8'h00);
        chk("comb_hold_o",   c1_o(), 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
